// File: rtl/pipeline_hazard_ctrl_if.sv
// Interface between the pipeline stages and the hazard controller.
// The master side reports stage occupancy; the slave side is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             two_src;
    logic [REG_W-1:0] ex_dest;
    logic             ex_wb_en;
    logic             ex_mem_r_en;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             fwd_en;
    logic             mem_access;
    logic             mem_ready;
    logic             Branch_taken;
    logic             cnt_clr;

    logic             freeze;
    logic             flush;
    logic             id_bubble;
    logic             stall_all;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output src1, src2, two_src,
        output ex_dest, ex_wb_en, ex_mem_r_en,
        output mem_dest, mem_wb_en,
        output fwd_en, mem_access, mem_ready, Branch_taken, cnt_clr,
        input  freeze, flush, id_bubble, stall_all, mem_err,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  src1, src2, two_src,
        input  ex_dest, ex_wb_en, ex_mem_r_en,
        input  mem_dest, mem_wb_en,
        input  fwd_en, mem_access, mem_ready, Branch_taken, cnt_clr,
        output freeze, flush, id_bubble, stall_all, mem_err,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central freeze/flush/bubble/stall controller for the 5-stage core, with
// a data-memory wait tracker, sticky timeout flag and saturating counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             mem_err_reg;
    logic             mem_err_next;

    logic             mem_stall;
    logic             hazard;
    logic             freeze;
    logic             flush;

    logic [REG_W-1:0] src_sel [2];
    logic [1:0]       src_used;
    logic [1:0]       ex_match;
    logic [1:0]       mem_match;

    // ------------------------------------------------------------------
    // Source-operand dependency check against EX and MEM writers
    // ------------------------------------------------------------------
    assign src_sel[0] = bus.src1;
    assign src_sel[1] = bus.src2;
    assign src_used   = {bus.two_src, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign ex_match[gi]  = src_used[gi] & bus.ex_wb_en  & (src_sel[gi] == bus.ex_dest);
            assign mem_match[gi] = src_used[gi] & bus.mem_wb_en & (src_sel[gi] == bus.mem_dest);
        end
    endgenerate

    // With forwarding only a load in EX cannot be bypassed in time.
    assign hazard = bus.fwd_en ? (bus.ex_mem_r_en & (|ex_match))
                               : ((|ex_match) | (|mem_match));

    // ------------------------------------------------------------------
    // Control outputs: memory stall beats branch, branch beats hazard
    // ------------------------------------------------------------------
    assign mem_stall = bus.mem_access & ~bus.mem_ready;
    assign freeze    = mem_stall | (hazard & ~bus.Branch_taken);
    assign flush     = bus.Branch_taken & ~mem_stall;

    assign bus.freeze    = freeze;
    assign bus.flush     = flush;
    assign bus.id_bubble = hazard & ~bus.Branch_taken & ~mem_stall;
    assign bus.stall_all = mem_stall;
    assign bus.mem_err   = mem_err_reg;

    // ------------------------------------------------------------------
    // Memory wait FSM and timeout tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = mem_err_reg;
        case (state_reg)
            RUN: begin
                wait_cnt_next = '0;
                if (mem_stall) begin
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt_reg != TIMEOUT_VAL) begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
                // Flag is raised once, on the edge the count arrives at the limit.
                if (wait_cnt_reg == TIMEOUT_LAST) begin
                    mem_err_next = 1'b1;
                end
                if (bus.mem_ready) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (bus.cnt_clr) begin
            mem_err_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters: [0] freeze cycles, [1] flush cycles
    // ------------------------------------------------------------------
    logic [1:0]       cnt_event;
    logic [CNT_W-1:0] cnt_value [2];

    assign cnt_event = {flush, freeze};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (bus.cnt_clr) begin
                    cnt_reg <= '0;
                end else if (cnt_event[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign cnt_value[gi] = cnt_reg;
        end
    endgenerate

    assign bus.stall_cnt = cnt_value[0];
    assign bus.flush_cnt = cnt_value[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a
// cycle-level reference model built from the controller's rules.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W       = 4;
    localparam int CNT_W       = 16;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .REG_W      (REG_W),
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit quiet    = 1'b0;

    // Reference model state
    int m_stall;
    int m_flush;
    bit m_in_wait;
    int m_wait_cycles;
    bit m_err;
    bit e_freeze;
    bit e_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stall       = 0;
        m_flush       = 0;
        m_in_wait     = 1'b0;
        m_wait_cycles = 0;
        m_err         = 1'b0;
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // A read depends on any in-flight writer of the same register; with
    // forwarding only a load sitting in EX still blocks.
    function automatic bit model_hazard();
        int reads[$];
        bit hit;
        hit = 1'b0;
        reads.push_back(int'(bus.src1));
        if (bus.two_src) reads.push_back(int'(bus.src2));
        foreach (reads[k]) begin
            if (bus.fwd_en) begin
                if (bus.ex_mem_r_en && bus.ex_wb_en && reads[k] == int'(bus.ex_dest)) hit = 1'b1;
            end else begin
                if (bus.ex_wb_en && reads[k] == int'(bus.ex_dest)) hit = 1'b1;
                if (bus.mem_wb_en && reads[k] == int'(bus.mem_dest)) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    task automatic set_idle();
        bus.src1 = '0; bus.src2 = '0; bus.two_src = 1'b0;
        bus.ex_dest = '0; bus.ex_wb_en = 1'b0; bus.ex_mem_r_en = 1'b0;
        bus.mem_dest = '0; bus.mem_wb_en = 1'b0; bus.fwd_en = 1'b0;
        bus.mem_access = 1'b0; bus.mem_ready = 1'b0;
        bus.Branch_taken = 1'b0; bus.cnt_clr = 1'b0;
    endtask

    task automatic set_random();
        bus.src1         = REG_W'($urandom_range(0, 3));
        bus.src2         = REG_W'($urandom_range(0, 3));
        bus.two_src      = 1'($urandom);
        bus.ex_dest      = REG_W'($urandom_range(0, 3));
        bus.ex_wb_en     = 1'($urandom);
        bus.ex_mem_r_en  = 1'($urandom);
        bus.mem_dest     = REG_W'($urandom_range(0, 3));
        bus.mem_wb_en    = 1'($urandom);
        bus.fwd_en       = 1'($urandom);
        bus.mem_access   = ($urandom_range(0, 2) != 0);
        bus.mem_ready    = 1'($urandom);
        bus.Branch_taken = ($urandom_range(0, 3) == 0);
        bus.cnt_clr      = ($urandom_range(0, 39) == 0);
    endtask

    // Move to the sampling point (falling edge) and compare every output.
    task automatic settle_and_check();
        bit ms, br, hz;
        @(negedge clk);
        ms = bus.mem_access & ~bus.mem_ready;
        br = bus.Branch_taken;
        hz = model_hazard();
        e_freeze = ms | (hz & ~br);
        e_flush  = br & ~ms;
        chk("freeze",    32'(bus.freeze),    32'(e_freeze));
        chk("flush",     32'(bus.flush),     32'(e_flush));
        chk("id_bubble", 32'(bus.id_bubble), 32'(hz & ~br & ~ms));
        chk("stall_all", 32'(bus.stall_all), 32'(ms));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(sat(m_stall)));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(sat(m_flush)));
        chk("mem_err",   32'(bus.mem_err),   32'(m_err));
        if (!quiet)
            $display("t=%0t s1=%0d s2=%0d two=%0b ex=%0d/%0b/%0b mem=%0d/%0b fwd=%0b acc=%0b rdy=%0b br=%0b clr=%0b -> frz=%0b fl=%0b bub=%0b stl=%0b err=%0b sc=%0d fc=%0d",
                $time, bus.src1, bus.src2, bus.two_src, bus.ex_dest, bus.ex_wb_en, bus.ex_mem_r_en,
                bus.mem_dest, bus.mem_wb_en, bus.fwd_en, bus.mem_access, bus.mem_ready,
                bus.Branch_taken, bus.cnt_clr, bus.freeze, bus.flush, bus.id_bubble,
                bus.stall_all, bus.mem_err, bus.stall_cnt, bus.flush_cnt);
    endtask

    // Take the rising edge and advance the model by one cycle.
    task automatic tick();
        bit reached;
        @(posedge clk);
        reached = 1'b0;
        if (bus.cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (e_freeze) m_stall++;
            if (e_flush)  m_flush++;
        end
        if (m_in_wait) begin
            m_wait_cycles++;
            if (m_wait_cycles == MEM_TIMEOUT) reached = 1'b1;
            if (bus.mem_ready) m_in_wait = 1'b0;
        end else begin
            m_wait_cycles = 0;
            if (bus.mem_access && !bus.mem_ready) m_in_wait = 1'b1;
        end
        m_err = bus.cnt_clr ? 1'b0 : (m_err | reached);
        #1;
    endtask

    task automatic cycle();
        settle_and_check();
        tick();
    endtask

    initial begin
        int exp_flush;

        // Reset with arbitrary inputs: state clears without any clock edge.
        set_random();
        rst = 1'b0;
        model_reset();
        #3;
        chk("rst_async_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst_async_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        chk("rst_async_mem_err",   32'(bus.mem_err),   32'd0);
        @(negedge clk);
        set_idle();
        #2;
        rst = 1'b1;
        #1;
        settle_and_check();
        chk("rst_idle_freeze", 32'(bus.freeze), 32'd0);
        chk("rst_idle_flush",  32'(bus.flush),  32'd0);
        tick();

        // Non-forwarding RAW hazard on src1.
        set_idle();
        bus.src1 = 4'd3; bus.ex_wb_en = 1'b1; bus.ex_dest = 4'd3;
        settle_and_check();
        chk("raw_src1_freeze", 32'(bus.freeze),    32'd1);
        chk("raw_src1_bubble", 32'(bus.id_bubble), 32'd1);
        tick();

        // src2 matches but is not read.
        bus.src1 = 4'd5; bus.src2 = 4'd3; bus.two_src = 1'b0;
        settle_and_check();
        chk("src2_unused_freeze", 32'(bus.freeze), 32'd0);
        tick();

        // Forwarding on: load-use on src2.
        set_idle();
        bus.fwd_en = 1'b1; bus.ex_mem_r_en = 1'b1; bus.ex_wb_en = 1'b1;
        bus.ex_dest = 4'd7; bus.src2 = 4'd7; bus.two_src = 1'b1; bus.src1 = 4'd1;
        settle_and_check();
        chk("load_use_freeze", 32'(bus.freeze),    32'd1);
        chk("load_use_bubble", 32'(bus.id_bubble), 32'd1);
        tick();
        bus.ex_mem_r_en = 1'b0;
        settle_and_check();
        chk("fwd_no_load_freeze", 32'(bus.freeze), 32'd0);
        tick();

        // r0 is a real register.
        set_idle();
        bus.mem_wb_en = 1'b1; bus.mem_dest = 4'd0; bus.src1 = 4'd0;
        settle_and_check();
        chk("r0_hazard_freeze", 32'(bus.freeze), 32'd1);
        tick();

        // Branch wins over hazard.
        bus.Branch_taken = 1'b1;
        exp_flush = m_flush + 1;
        settle_and_check();
        chk("br_haz_flush",  32'(bus.flush),     32'd1);
        chk("br_haz_freeze", 32'(bus.freeze),    32'd0);
        chk("br_haz_bubble", 32'(bus.id_bubble), 32'd0);
        tick();
        set_idle();
        settle_and_check();
        chk("br_flush_cnt_inc", 32'(bus.flush_cnt), 32'(exp_flush));
        tick();

        // Memory stall with a pending branch: flush deferred to mem_ready cycle.
        set_idle();
        bus.cnt_clr = 1'b1;
        cycle();
        bus.cnt_clr = 1'b0;
        bus.mem_access = 1'b1; bus.Branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle_and_check();
            chk("memstall_stall_all", 32'(bus.stall_all), 32'd1);
            chk("memstall_freeze",    32'(bus.freeze),    32'd1);
            chk("memstall_flush",     32'(bus.flush),     32'd0);
            tick();
        end
        bus.mem_ready = 1'b1;
        settle_and_check();
        chk("memready_flush", 32'(bus.flush), 32'd1);
        chk("memready_stall_cnt", 32'(bus.stall_cnt), 32'd5);
        tick();

        // Timeout: 10 cycles without mem_ready.
        set_idle();
        bus.cnt_clr = 1'b1;
        cycle();
        bus.cnt_clr = 1'b0;
        bus.mem_access = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            settle_and_check();
            chk("timeout_mem_err",   32'(bus.mem_err),   32'(i >= MEM_TIMEOUT + 2));
            chk("timeout_stall_all", 32'(bus.stall_all), 32'd1);
            tick();
        end
        bus.cnt_clr = 1'b1;
        cycle();
        bus.cnt_clr = 1'b0;
        settle_and_check();
        chk("clr_mem_err",   32'(bus.mem_err),   32'd0);
        chk("clr_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        tick();
        bus.mem_ready = 1'b1;
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_random();
            cycle();
        end

        // Counter saturation: more freeze cycles than the counter can hold.
        set_idle();
        bus.cnt_clr = 1'b1;
        cycle();
        bus.cnt_clr = 1'b0;
        bus.src1 = 4'd1; bus.ex_dest = 4'd1; bus.ex_wb_en = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < CNT_MAX + 4; i++) cycle();
        quiet = 1'b0;
        settle_and_check();
        chk("stall_cnt_saturated", 32'(bus.stall_cnt), 32'hFFFF);
        tick();

        // Reset in the middle of a memory wait.
        set_idle();
        bus.mem_access = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midwait_rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("midwait_rst_mem_err",   32'(bus.mem_err),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        settle_and_check();
        chk("midwait_rst_freeze", 32'(bus.freeze), 32'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            set_random();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
